// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD sequencer.
// Holds the state encoding, init ROM and command helpers.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_SETUP,
    ST_E_HIGH,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } state_t;

  localparam int INIT_LEN = 4;
  localparam int IDX_W    = 2;

  localparam logic [7:0] CMD_FUNCSET = 8'h38;
  localparam logic [7:0] CMD_DISPON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_HOME_B  = 8'h03;

  function automatic logic [7:0] init_byte(
    input logic [IDX_W-1:0] idx
  );
    logic [7:0] b;
    b = CMD_FUNCSET;
    case (idx)
      2'd0:    b = CMD_FUNCSET;
      2'd1:    b = CMD_DISPON;
      2'd2:    b = CMD_CLEAR;
      2'd3:    b = CMD_ENTRY;
      default: b = CMD_FUNCSET;
    endcase
    return b;
  endfunction

  // Clear and home need the long execution wait.
  function automatic logic is_long_cmd(
    input logic       rs,
    input logic [7:0] data
  );
    return !rs && (data == CMD_CLEAR ||
                   data == CMD_HOME  ||
                   data == CMD_HOME_B);
  endfunction

endpackage

// File: rtl/lcd_sequencer_timer.sv
// Loadable down-counter with zero flag; holds at zero.
// The reset value lets the first state start timing immediately.
module lcd_timer #(
  parameter int               CNT_W   = 20,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780 write sequencer: power-up delay, init ROM, then
// single-byte command/data writes through a ready/req handshake.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 4,
  parameter int E_HIGH_CYC     = 25,
  parameter int HOLD_CYC       = 4,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int POWERUP_CYC    = 750000,
  parameter int CNT_W          = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       ready,
  output logic       done,
  output logic       init_done,
  output logic       RS,
  output logic       RW,
  output logic       E,
  output logic [7:0] DB,
  output logic       LCD_On,
  output logic       LCD_Blon
);

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(INIT_LEN - 1);

  state_t           state;
  state_t           state_n;
  logic             zero;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_n;
  logic             rs_n;
  logic [7:0]       db_n;
  logic             e_n;
  logic             ready_n;
  logic             done_n;
  logic             init_n;

  lcd_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(POWERUP_CYC - 1))
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_POWERUP;
      idx       <= '0;
      E         <= 1'b0;
      RS        <= 1'b0;
      RW        <= 1'b0;
      DB        <= 8'h00;
      ready     <= 1'b0;
      done      <= 1'b0;
      init_done <= 1'b0;
      LCD_On    <= 1'b1;
      LCD_Blon  <= 1'b1;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      E         <= e_n;
      RS        <= rs_n;
      RW        <= 1'b0;
      DB        <= db_n;
      ready     <= ready_n;
      done      <= done_n;
      init_done <= init_n;
      LCD_On    <= 1'b1;
      LCD_Blon  <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_POWERUP: if (zero) state_n = ST_SETUP;
      ST_SETUP:   if (zero) state_n = ST_E_HIGH;
      ST_E_HIGH:  if (zero) state_n = ST_HOLD;
      ST_HOLD:    if (zero) state_n = ST_WAIT;
      ST_WAIT: begin
        if (zero) begin
          if (!init_done && idx != LAST_IDX) begin
            state_n = ST_SETUP;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_IDLE:    if (req) state_n = ST_SETUP;
      default:    state_n = ST_POWERUP;
    endcase
  end

  // Timer is reloaded with N-1 on every state entry.
  always_comb begin
    load     = (state_n != state);
    load_val = '0;
    unique case (state_n)
      ST_SETUP:  load_val = CNT_W'(SETUP_CYC - 1);
      ST_E_HIGH: load_val = CNT_W'(E_HIGH_CYC - 1);
      ST_HOLD:   load_val = CNT_W'(HOLD_CYC - 1);
      ST_WAIT: begin
        if (is_long_cmd(RS, DB)) begin
          load_val = CNT_W'(CLEAR_WAIT_CYC - 1);
        end else begin
          load_val = CNT_W'(CMD_WAIT_CYC - 1);
        end
      end
      default:   load_val = '0;
    endcase
  end

  always_comb begin
    rs_n    = RS;
    db_n    = DB;
    idx_n   = idx;
    init_n  = init_done;
    done_n  = 1'b0;
    e_n     = (state_n == ST_E_HIGH);
    ready_n = (state_n == ST_IDLE);
    unique case (state)
      ST_POWERUP: begin
        if (zero) begin
          rs_n  = 1'b0;
          db_n  = init_byte('0);
          idx_n = '0;
        end
      end
      ST_WAIT: begin
        if (zero) begin
          if (init_done) begin
            done_n = 1'b1;
          end else if (idx != LAST_IDX) begin
            idx_n = idx + 1'b1;
            rs_n  = 1'b0;
            db_n  = init_byte(idx + 1'b1);
          end else begin
            init_n = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (req) begin
          rs_n = req_rs;
          db_n = req_data;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed and randomized checks of lcd_sequencer against an
// event-timeline model built from the write timing rules.
module tb_lcd_sequencer;

  localparam int S  = 2;
  localparam int EH = 12;
  localparam int H  = 2;
  localparam int CW = 20;
  localparam int LW = 100;
  localparam int P  = 50;

  logic       clock = 1'b0;
  logic       reset;
  logic       req;
  logic       req_rs;
  logic [7:0] req_data;
  logic       ready;
  logic       done;
  logic       init_done;
  logic       RS;
  logic       RW;
  logic       E;
  logic [7:0] DB;
  logic       LCD_On;
  logic       LCD_Blon;

  lcd_sequencer #(
    .SETUP_CYC      (S),
    .E_HIGH_CYC     (EH),
    .HOLD_CYC       (H),
    .CMD_WAIT_CYC   (CW),
    .CLEAR_WAIT_CYC (LW),
    .POWERUP_CYC    (P),
    .CNT_W          (20)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .ready     (ready),
    .done      (done),
    .init_done (init_done),
    .RS        (RS),
    .RW        (RW),
    .E         (E),
    .DB        (DB),
    .LCD_On    (LCD_On),
    .LCD_Blon  (LCD_Blon)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic       rs;
    logic [7:0] db;
  } pulse_t;

  pulse_t rises[$];
  int     falls[$];
  int     dones[$];
  int     rdy_up[$];
  int     ini_up[$];
  int     unstable = 0;
  int     rw_bad   = 0;
  logic   e_q = 1'b0;
  logic   r_q = 1'b0;
  logic   i_q = 1'b0;
  pulse_t cur;

  always @(negedge clock) begin
    if (E === 1'b1 && !e_q) rises.push_back('{cyc, RS, DB});
    if (E === 1'b1 && !e_q) cur <= '{cyc, RS, DB};
    if (E === 1'b0 && e_q) falls.push_back(cyc);
    if (E === 1'b1 && e_q && (RS !== cur.rs || DB !== cur.db))
      unstable <= unstable + 1;
    if (done === 1'b1) dones.push_back(cyc);
    if (ready === 1'b1 && !r_q) rdy_up.push_back(cyc);
    if (init_done === 1'b1 && !i_q) ini_up.push_back(cyc);
    if (RW !== 1'b0 && reset === 1'b0) rw_bad <= rw_bad + 1;
    e_q <= (E === 1'b1);
    r_q <= (ready === 1'b1);
    i_q <= (init_done === 1'b1);
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_q();
    rises.delete();
    falls.delete();
    dones.delete();
    rdy_up.delete();
    ini_up.delete();
  endtask

  function automatic int wait_of(logic rs, logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03))
           ? LW : CW;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 300 && ready !== 1'b1; i++) tick();
    chk("wait_ready", int'(ready === 1'b1), 1);
  endtask

  // Stray req pulses during init must be ignored.
  task automatic check_init(input int t0);
    int ok;
    int r;
    int f;
    int end_t;
    ok = 0;
    for (int i = 0; i < 3000 && ok == 0; i++) begin
      tick();
      req      = (i == 10 || i == 60);
      req_rs   = 1'b1;
      req_data = 8'h55;
      if (init_done === 1'b1) ok = 1;
    end
    req = 1'b0;
    chk("init_timeout", ok, 1);
    chk("init_pulses", rises.size(), 4);
    chk("init_falls", falls.size(), 4);
    r = t0 + P + S;
    end_t = 0;
    for (int k = 0; k < 4; k++) begin
      f = r + EH;
      if (k < rises.size()) begin
        chk("init_rise_t", rises[k].t, r);
        chk("init_db", int'(rises[k].db), int'(rom[k]));
        chk("init_rs", int'(rises[k].rs), 0);
      end
      if (k < falls.size()) chk("init_fall_t", falls[k], f);
      end_t = f + H + wait_of(1'b0, rom[k]);
      r = end_t + S;
    end
    chk("init_done_n", ini_up.size(), 1);
    if (ini_up.size() > 0) chk("init_done_t", ini_up[0], end_t);
    chk("init_rdy_n", rdy_up.size(), 1);
    if (rdy_up.size() > 0) chk("init_rdy_t", rdy_up[0], end_t);
    chk("init_no_done", dones.size(), 0);
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d);
    int a;
    int lat;
    int ok;
    wait_ready();
    clear_q();
    req      = 1'b1;
    req_rs   = rs;
    req_data = d;
    a        = cyc + 1;
    tick();
    req      = 1'b0;
    req_rs   = ~rs;
    req_data = 8'($urandom);
    chk("wr_ready_drop", int'(ready), 0);
    lat = S + EH + H + wait_of(rs, d);
    ok  = 0;
    for (int i = 0; i < lat + 50 && ok == 0; i++) begin
      if (done === 1'b1) ok = 1;
      else begin
        tick();
        req = (i == 5);
      end
    end
    req = 1'b0;
    chk("wr_timeout", ok, 1);
    chk("wr_done_t", cyc, a + lat);
    chk("wr_ready_at_done", int'(ready), 1);
    chk("wr_pulses", rises.size(), 1);
    if (rises.size() > 0) begin
      chk("wr_rise_t", rises[0].t, a + S);
      chk("wr_rs", int'(rises[0].rs), int'(rs));
      chk("wr_db", int'(rises[0].db), int'(d));
    end
    if (falls.size() > 0) chk("wr_fall_t", falls[0], a + S + EH);
    tick();
    chk("wr_done_pulse", int'(done), 0);
  endtask

  // req held high: each done cycle accepts the next byte.
  task automatic b2b(input int n);
    int a;
    int lat;
    int exp_r[$];
    int ok;
    lat = S + EH + H + CW;
    wait_ready();
    clear_q();
    req      = 1'b1;
    req_rs   = 1'b1;
    req_data = 8'h41;
    a        = cyc + 1;
    for (int k = 0; k < n; k++) begin
      exp_r.push_back(a + S);
      ok = 0;
      for (int i = 0; i < lat + 20 && ok == 0; i++) begin
        tick();
        if (done === 1'b1) ok = 1;
      end
      chk("b2b_timeout", ok, 1);
      chk("b2b_done_t", cyc, a + lat);
      chk("b2b_ready", int'(ready), 1);
      a = cyc + 1;
      if (k == n - 1) req = 1'b0;
    end
    tick();
    chk("b2b_pulses", rises.size(), n);
    for (int k = 0; k < n && k < rises.size(); k++) begin
      chk("b2b_rise_t", rises[k].t, exp_r[k]);
      chk("b2b_db", int'(rises[k].db), 8'h41);
    end
  endtask

  task automatic reset_mid_write();
    int t0;
    int ok;
    wait_ready();
    req      = 1'b1;
    req_rs   = 1'b1;
    req_data = 8'($urandom);
    tick();
    req = 1'b0;
    ok  = 0;
    for (int i = 0; i < 50 && ok == 0; i++) begin
      tick();
      if (E === 1'b1) ok = 1;
    end
    chk("rst_saw_e", ok, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_e", int'(E), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_db", int'(DB), 0);
    clear_q();
    t0    = cyc;
    reset = 1'b0;
    check_init(t0);
  endtask

  initial begin
    int t0;
    logic       rs;
    logic [7:0] d;
    reset    = 1'b1;
    req      = 1'b0;
    req_rs   = 1'b0;
    req_data = 8'h00;
    tick();
    tick();
    tick();
    chk("rst_vals", int'({E, RS, RW, ready, done, init_done}), 0);
    chk("rst_db0", int'(DB), 0);
    chk("rst_pwr", int'({LCD_On, LCD_Blon}), 3);
    clear_q();
    t0    = cyc;
    reset = 1'b0;
    check_init(t0);

    do_write(1'b1, 8'h41);
    do_write(1'b0, 8'h01);
    do_write(1'b0, 8'h80);
    for (int k = 0; k < 5; k++) begin
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(1, 3));
      else d = 8'($urandom);
      do_write(rs, d);
    end
    b2b(3);
    reset_mid_write();
    do_write(1'b1, 8'h42);

    chk("rsdb_stable", unstable, 0);
    chk("rw_zero", rw_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
